// File: rtl/iq_scheduler.sv
// Issue-queue allocation, wakeup and select controller: tracks per-slot occupancy,
// source readiness and ROB age. Define IQ_AGE_SELECT_EN for oldest-first select.
module iq_scheduler #(
   parameter int ENTRIES = 8,
   parameter int PREG_W  = 6,
   parameter int ROB_W   = 6
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enq_valid,
   output logic                         enq_ready,
   input  logic [PREG_W-1:0]            enq_prs1,
   input  logic [PREG_W-1:0]            enq_prs2,
   input  logic                         enq_src1_state,
   input  logic                         enq_src2_state,
   input  logic                         enq_robidx_flag,
   input  logic [ROB_W-1:0]             enq_robidx,
   output logic [ENTRIES-1:0]           enq_slot_sel,
   input  logic                         writeback0_valid,
   input  logic [PREG_W-1:0]            writeback0_prd,
   input  logic                         writeback1_valid,
   input  logic [PREG_W-1:0]            writeback1_prd,
   output logic                         issue_valid,
   input  logic                         issue_ready,
   output logic [ENTRIES-1:0]           issue_slot_sel,
   output logic                         issue_robidx_flag,
   output logic [ROB_W-1:0]             issue_robidx,
   input  logic                         flush_valid,
   input  logic                         flush_robidx_flag,
   input  logic [ROB_W-1:0]             flush_robidx,
   output logic [$clog2(ENTRIES):0]     occupancy
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int OCC_W = IDX_W + 1;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [ENTRIES-1:0] s1_q, s1_d;
   logic [ENTRIES-1:0] s2_q, s2_d;
   logic [ENTRIES-1:0] flag_q, flag_d;
   logic [PREG_W-1:0]  prs1_q [ENTRIES];
   logic [PREG_W-1:0]  prs1_d [ENTRIES];
   logic [PREG_W-1:0]  prs2_q [ENTRIES];
   logic [PREG_W-1:0]  prs2_d [ENTRIES];
   logic [ROB_W-1:0]   rob_q  [ENTRIES];
   logic [ROB_W-1:0]   rob_d  [ENTRIES];

   logic [ENTRIES-1:0] elig;
   logic [IDX_W-1:0]   free_idx, sel_idx;
   logic               free_any, sel_any;
   logic [OCC_W-1:0]   occ;
   logic               enq_fire, issue_fire;

   function automatic logic younger(input logic fa, input logic [ROB_W-1:0] ia,
                                    input logic fb, input logic [ROB_W-1:0] ib);
      return ((fa == fb) && (ia > ib)) || ((fa != fb) && (ia < ib));
   endfunction

   function automatic logic wb_hit(input logic [PREG_W-1:0] prs,
                                   input logic v0, input logic [PREG_W-1:0] p0,
                                   input logic v1, input logic [PREG_W-1:0] p1);
      return (v0 && (p0 == prs)) || (v1 && (p1 == prs));
   endfunction

   always_comb begin
      occ      = '0;
      free_idx = '0;
      free_any = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         occ = occ + OCC_W'(valid_q[i]);
         if (!valid_q[i]) begin
            free_idx = IDX_W'(i);
            free_any = 1'b1;
         end
      end
   end

   assign elig = valid_q & s1_q & s2_q;

`ifdef IQ_AGE_SELECT_EN
   // Pairwise tournament: each level keeps the older of two eligible candidates.
   logic             lv_v [IDX_W+1][ENTRIES];
   logic [IDX_W-1:0] lv_i [IDX_W+1][ENTRIES];

   always_comb begin
      for (int l = 0; l <= IDX_W; l++) begin
         for (int i = 0; i < ENTRIES; i++) begin
            lv_v[l][i] = 1'b0;
            lv_i[l][i] = '0;
         end
      end
      for (int i = 0; i < ENTRIES; i++) begin
         lv_v[0][i] = elig[i];
         lv_i[0][i] = IDX_W'(i);
      end
      for (int l = 0; l < IDX_W; l++) begin
         for (int i = 0; i < (ENTRIES >> (l + 1)); i++) begin
            if (lv_v[l][2*i+1] && (!lv_v[l][2*i] ||
                younger(flag_q[lv_i[l][2*i]], rob_q[lv_i[l][2*i]],
                        flag_q[lv_i[l][2*i+1]], rob_q[lv_i[l][2*i+1]]))) begin
               lv_v[l+1][i] = 1'b1;
               lv_i[l+1][i] = lv_i[l][2*i+1];
            end else begin
               lv_v[l+1][i] = lv_v[l][2*i];
               lv_i[l+1][i] = lv_i[l][2*i];
            end
         end
      end
      sel_any = lv_v[IDX_W][0];
      sel_idx = lv_i[IDX_W][0];
   end
`else
   always_comb begin
      sel_any = 1'b0;
      sel_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (elig[i]) begin
            sel_any = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
   end
`endif

   // Handshakes: a transfer happens only in a cycle where valid and ready are both
   // high and no flush is presented; valid never waits on ready.
   assign enq_ready  = (occ < OCC_W'(ENTRIES));
   assign enq_fire   = enq_valid && enq_ready && !flush_valid && free_any;
   assign issue_fire = sel_any && issue_ready && !flush_valid;

   assign occupancy         = occ;
   assign enq_slot_sel      = enq_fire ? (ENTRIES'(1) << free_idx) : '0;
   assign issue_valid       = sel_any;
   assign issue_slot_sel    = sel_any ? (ENTRIES'(1) << sel_idx) : '0;
   assign issue_robidx_flag = sel_any ? flag_q[sel_idx] : 1'b0;
   assign issue_robidx      = sel_any ? rob_q[sel_idx] : '0;

   always_comb begin
      valid_d = valid_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      flag_d  = flag_q;
      prs1_d  = prs1_q;
      prs2_d  = prs2_q;
      rob_d   = rob_q;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i]) begin
            if (wb_hit(prs1_q[i], writeback0_valid, writeback0_prd,
                       writeback1_valid, writeback1_prd)) s1_d[i] = 1'b1;
            if (wb_hit(prs2_q[i], writeback0_valid, writeback0_prd,
                       writeback1_valid, writeback1_prd)) s2_d[i] = 1'b1;
            if (flush_valid && younger(flag_q[i], rob_q[i], flush_robidx_flag, flush_robidx))
               valid_d[i] = 1'b0;
         end
      end
      if (issue_fire) valid_d[sel_idx] = 1'b0;
      if (enq_fire) begin
         valid_d[free_idx] = 1'b1;
         flag_d[free_idx]  = enq_robidx_flag;
         rob_d[free_idx]   = enq_robidx;
         prs1_d[free_idx]  = enq_prs1;
         prs2_d[free_idx]  = enq_prs2;
         s1_d[free_idx]    = enq_src1_state || wb_hit(enq_prs1, writeback0_valid,
                             writeback0_prd, writeback1_valid, writeback1_prd);
         s2_d[free_idx]    = enq_src2_state || wb_hit(enq_prs2, writeback0_valid,
                             writeback0_prd, writeback1_valid, writeback1_prd);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         flag_q  <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            prs1_q[i] <= '0;
            prs2_q[i] <= '0;
            rob_q[i]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         flag_q  <= flag_d;
         prs1_q  <= prs1_d;
         prs2_q  <= prs2_d;
         rob_q   <= rob_d;
      end
   end

endmodule

// File: tb/tb_iq_scheduler.sv
// Directed bench for iq_scheduler: issue-tag scoreboard plus status checks.
module tb_iq_scheduler;

   localparam int ENTRIES = 8;
   localparam int PREG_W  = 6;
   localparam int ROB_W   = 6;
   localparam int W       = ENTRIES + 1 + ROB_W;

   logic               clock, reset;
   logic               enq_valid, enq_ready;
   logic [PREG_W-1:0]  enq_prs1, enq_prs2;
   logic               enq_src1_state, enq_src2_state;
   logic               enq_robidx_flag;
   logic [ROB_W-1:0]   enq_robidx;
   logic [ENTRIES-1:0] enq_slot_sel;
   logic               writeback0_valid, writeback1_valid;
   logic [PREG_W-1:0]  writeback0_prd, writeback1_prd;
   logic               issue_valid, issue_ready;
   logic [ENTRIES-1:0] issue_slot_sel;
   logic               issue_robidx_flag;
   logic [ROB_W-1:0]   issue_robidx;
   logic               flush_valid, flush_robidx_flag;
   logic [ROB_W-1:0]   flush_robidx;
   logic [$clog2(ENTRIES):0] occupancy;

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   iq_scheduler #(.ENTRIES(ENTRIES), .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
      .clock(clock), .reset(reset),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
      .enq_src1_state(enq_src1_state), .enq_src2_state(enq_src2_state),
      .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
      .enq_slot_sel(enq_slot_sel),
      .writeback0_valid(writeback0_valid), .writeback0_prd(writeback0_prd),
      .writeback1_valid(writeback1_valid), .writeback1_prd(writeback1_prd),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_slot_sel(issue_slot_sel),
      .issue_robidx_flag(issue_robidx_flag), .issue_robidx(issue_robidx),
      .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag),
      .flush_robidx(flush_robidx), .occupancy(occupancy)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [W-1:0] pk(input int slot, input logic f, input logic [ROB_W-1:0] r);
      logic [ENTRIES-1:0] oh;
      oh = ENTRIES'(1) << slot;
      return {oh, f, r};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic enq(input logic [PREG_W-1:0] p1, input logic s1,
                      input logic [PREG_W-1:0] p2, input logic s2,
                      input logic f, input logic [ROB_W-1:0] rob, input int exp_slot);
      enq_valid = 1'b1;
      enq_prs1 = p1; enq_src1_state = s1;
      enq_prs2 = p2; enq_src2_state = s2;
      enq_robidx_flag = f; enq_robidx = rob;
      @(negedge clock);
      chk("enq_slot_sel", int'(enq_slot_sel), 1 << exp_slot);
      step();
      enq_valid = 1'b0;
   endtask

   // monitor: every accepted issue is popped and compared against the expected tag
   always @(negedge clock) begin
      if (!reset && issue_valid && issue_ready && !flush_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL issue_tag: got %h expected nothing",
                     {issue_slot_sel, issue_robidx_flag, issue_robidx});
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if ({issue_slot_sel, issue_robidx_flag, issue_robidx} !== e) begin
               n_err++;
               $display("FAIL issue_tag: got %h expected %h",
                        {issue_slot_sel, issue_robidx_flag, issue_robidx}, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      enq_valid = 0; enq_prs1 = 0; enq_prs2 = 0; enq_src1_state = 0; enq_src2_state = 0;
      enq_robidx_flag = 0; enq_robidx = 0;
      writeback0_valid = 0; writeback0_prd = 0; writeback1_valid = 0; writeback1_prd = 0;
      issue_ready = 0; flush_valid = 0; flush_robidx_flag = 0; flush_robidx = 0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // reset state
      @(negedge clock);
      chk("rst_enq_ready", int'(enq_ready), 1);
      chk("rst_issue_valid", int'(issue_valid), 0);
      chk("rst_occupancy", int'(occupancy), 0);
      chk("rst_enq_slot_sel", int'(enq_slot_sel), 0);
      chk("rst_issue_slot_sel", int'(issue_slot_sel), 0);
      step();

      // fill all slots in order
      for (int i = 0; i < ENTRIES; i++) enq(0, 1, 0, 1, 0, ROB_W'(20 + i), i);
      @(negedge clock);
      chk("full_enq_ready", int'(enq_ready), 0);
      chk("full_occupancy", int'(occupancy), 8);
      chk("full_issue_sel", int'(issue_slot_sel), 1);
      step();
      exp_q.push_back(pk(0, 0, 20));
      issue_ready = 1;
      @(negedge clock);
      chk("full_issue_enq_ready", int'(enq_ready), 0);
      step();
      issue_ready = 0;
      @(negedge clock);
      chk("after_issue_enq_ready", int'(enq_ready), 1);
      chk("after_issue_occupancy", int'(occupancy), 7);
      step();
      for (int i = 1; i < ENTRIES; i++) exp_q.push_back(pk(i, 0, ROB_W'(20 + i)));
      issue_ready = 1;
      repeat (7) step();
      issue_ready = 0;
      @(negedge clock);
      chk("drain_occupancy", int'(occupancy), 0);
      chk("drain_issue_valid", int'(issue_valid), 0);
      step();

      // same-cycle writeback bypass on src1
      writeback0_valid = 1; writeback0_prd = 5;
      enq(5, 0, 0, 1, 0, 30, 0);
      writeback0_valid = 0;
      @(negedge clock);
      chk("bypass_issue_valid", int'(issue_valid), 1);
      step();
      exp_q.push_back(pk(0, 0, 30));
      issue_ready = 1; step(); issue_ready = 0;

      // non-matching writeback, then later wakeup
      writeback0_valid = 1; writeback0_prd = 6;
      enq(5, 0, 0, 1, 0, 31, 0);
      writeback0_valid = 0;
      @(negedge clock);
      chk("nomatch_issue_valid0", int'(issue_valid), 0);
      step();
      @(negedge clock);
      chk("nomatch_issue_valid1", int'(issue_valid), 0);
      step();
      writeback1_valid = 1; writeback1_prd = 5;
      @(negedge clock);
      chk("wb_cycle_not_eligible", int'(issue_valid), 0);
      step();
      writeback1_valid = 0;
      @(negedge clock);
      chk("wakeup_issue_valid", int'(issue_valid), 1);
      chk("wakeup_issue_robidx", int'(issue_robidx), 31);
      step();
      exp_q.push_back(pk(0, 0, 31));
      issue_ready = 1; step(); issue_ready = 0;

      // src2 bypass from writeback port 1
      writeback1_valid = 1; writeback1_prd = 9;
      enq(0, 1, 9, 0, 0, 32, 0);
      writeback1_valid = 0;
      @(negedge clock);
      chk("bypass2_issue_valid", int'(issue_valid), 1);
      step();
      exp_q.push_back(pk(0, 0, 32));
      issue_ready = 1; step(); issue_ready = 0;

      // select policy across a ROB wrap
      enq(0, 1, 0, 1, 1, 3, 0);
      enq(0, 1, 0, 1, 0, 60, 1);
`ifdef IQ_AGE_SELECT_EN
      exp_q.push_back(pk(1, 0, 60));
      exp_q.push_back(pk(0, 1, 3));
`else
      exp_q.push_back(pk(0, 1, 3));
      exp_q.push_back(pk(1, 0, 60));
`endif
      issue_ready = 1; repeat (2) step(); issue_ready = 0;
      @(negedge clock);
      chk("age_occupancy", int'(occupancy), 0);
      step();

      // flush keeps the tagged entry, kills younger, blocks enqueue
      enq(40, 0, 40, 0, 0, 10, 0);
      enq(40, 0, 40, 0, 0, 11, 1);
      enq(40, 0, 40, 0, 0, 12, 2);
      @(negedge clock);
      chk("preflush_occupancy", int'(occupancy), 3);
      step();
      flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 11;
      enq_valid = 1; enq_prs1 = 0; enq_src1_state = 1; enq_prs2 = 0; enq_src2_state = 1;
      enq_robidx_flag = 0; enq_robidx = 13;
      @(negedge clock);
      chk("flush_enq_slot_sel", int'(enq_slot_sel), 0);
      step();
      flush_valid = 0; enq_valid = 0;
      @(negedge clock);
      chk("postflush_occupancy", int'(occupancy), 2);
      step();
      enq(0, 1, 0, 1, 0, 13, 2);
      writeback0_valid = 1; writeback0_prd = 40;
      step();
      writeback0_valid = 0;
      exp_q.push_back(pk(0, 0, 10));
      exp_q.push_back(pk(1, 0, 11));
      exp_q.push_back(pk(2, 0, 13));
      issue_ready = 1; repeat (3) step(); issue_ready = 0;

      // issue suppressed during a flush cycle
      enq(0, 1, 0, 1, 0, 50, 0);
      flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 50;
      issue_ready = 1;
      @(negedge clock);
      chk("flush_issue_valid_shown", int'(issue_valid), 1);
      step();
      flush_valid = 0; issue_ready = 0;
      @(negedge clock);
      chk("flush_blocks_issue_occ", int'(occupancy), 1);
      step();
      exp_q.push_back(pk(0, 0, 50));
      issue_ready = 1; step(); issue_ready = 0;

      // flush with a wrapped tag: flag-1 rob 1 is younger than flag-0 rob 63
      enq(40, 0, 40, 0, 0, 62, 0);
      enq(40, 0, 40, 0, 1, 1, 1);
      flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 63;
      step();
      flush_valid = 0;
      @(negedge clock);
      chk("wrapflush_occupancy", int'(occupancy), 1);
      step();
      writeback1_valid = 1; writeback1_prd = 40;
      step();
      writeback1_valid = 0;
      exp_q.push_back(pk(0, 0, 62));
      issue_ready = 1; step(); issue_ready = 0;

      // backpressure holds the selection
      enq(0, 1, 0, 1, 0, 5, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         chk("bp_issue_valid", int'(issue_valid), 1);
         chk("bp_issue_slot_sel", int'(issue_slot_sel), 1);
         step();
      end
      exp_q.push_back(pk(0, 0, 5));
      issue_ready = 1; step(); issue_ready = 0;
      @(negedge clock);
      chk("bp_release_occupancy", int'(occupancy), 0);
      chk("bp_release_issue_valid", int'(issue_valid), 0);
      step();

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
